// File: rtl/tdc_readout_ctrl.sv
// tdc_readout_ctrl
//   Run controller and result buffer for a time-to-digital converter.
//   A run arms the TDC once per shot (one-cycle oTdcRst, then oArm while the
//   conversion is pending). Each result is captured and pushed into a
//   first-word-fall-through FIFO with registered oData/oValid.
//
// Parameters
//   DIG_OUT        width of a TDC result word
//   FIFO_DEPTH     result buffer depth (power of 2, >= 2)
//   TIMEOUT_CYCLES WAIT-state cycle limit (>= 1), used only with the macro
//
// Ports
//   iClk, iRst           clock, synchronous active-high reset
//   iStart, iAbort       run request / immediate run termination
//   iShots               shots per run (0 = continuous), sampled on start
//   oTdcRst, oArm        TDC datapath reset pulse / conversion pending
//   iTdcValid, iTdc      conversion-finished pulse and result word
//   oData, oValid,iReady FIFO head word, valid flag, consumer handshake
//   oBusy, oDone         run in progress / normal completion pulse
//   oOverflow, oTimeout  sticky error flags
//
// Build option
//   TDC_READOUT_TIMEOUT_EN  when defined, WAIT gives up after TIMEOUT_CYCLES
//                           cycles, sets oTimeout and re-arms the TDC.

module tdc_readout_ctrl #(
    parameter int DIG_OUT        = 24,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStart,
    input  logic               iAbort,
    input  logic [7:0]         iShots,
    output logic               oTdcRst,
    output logic               oArm,
    input  logic               iTdcValid,
    input  logic [DIG_OUT-1:0] iTdc,
    output logic [DIG_OUT-1:0] oData,
    output logic               oValid,
    input  logic               iReady,
    output logic               oBusy,
    output logic               oDone,
    output logic               oOverflow,
    output logic               oTimeout
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("tdc_readout_ctrl: invalid FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [7:0]         shots_left;
    logic               continuous;
    logic [DIG_OUT-1:0] cap_word;

    logic [DIG_OUT-1:0] mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [AW:0]        wr_ptr_nx;
    logic [AW:0]        rd_ptr_nx;

    logic               start_ok;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               full;
    logic               drop;
    logic               tmo_expire;

    assign start_ok = (state == S_IDLE) && iStart && !iAbort;
    assign push_req = (state == S_STORE) && !iAbort;
    assign pop      = oValid && iReady;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign wr_ptr_nx = push ? wr_ptr + 1'b1 : wr_ptr;
    assign rd_ptr_nx = pop  ? rd_ptr + 1'b1 : rd_ptr;

`ifdef TDC_READOUT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;

    // Counts cycles spent in WAIT; any other state holds it at zero so it
    // starts from zero on every WAIT entry.
    always_ff @(posedge iClk) begin
        if (iRst || state != S_WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A conversion arriving in the expiry cycle takes precedence.
    assign tmo_expire = (state == S_WAIT) && !iTdcValid &&
                        (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge iClk) begin
        if (iRst || start_ok) begin
            oTimeout <= 1'b0;
        end else if (tmo_expire && !iAbort) begin
            oTimeout <= 1'b1;
        end
    end
`else
    assign tmo_expire = 1'b0;
    assign oTimeout   = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start_ok) state_nx = S_ARM;
            S_ARM:   state_nx = S_WAIT;
            S_WAIT: begin
                if (iTdcValid) begin
                    state_nx = S_STORE;
                end else if (tmo_expire) begin
                    state_nx = S_ARM;
                end
            end
            // shots_left == 1 here means this STORE brings it to zero.
            S_STORE: state_nx = (continuous || shots_left != 8'd1) ? S_ARM : S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (iAbort && state != S_IDLE) begin
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            shots_left <= '0;
            continuous <= 1'b0;
        end else if (start_ok) begin
            shots_left <= iShots;
            continuous <= (iShots == 8'd0);
        end else if (push_req && !continuous) begin
            shots_left <= shots_left - 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cap_word <= '0;
        end else if (state == S_WAIT && iTdcValid) begin
            cap_word <= iTdc;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst || start_ok) begin
            oOverflow <= 1'b0;
        end else if (drop) begin
            oOverflow <= 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= cap_word;
        end
    end

    // Output stage is loaded from the next-cycle head; when that head is the
    // slot being written now, take the incoming word instead of the stale
    // memory entry (it becomes visible one cycle later, never combinationally).
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            oValid <= 1'b0;
            oData  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
            oValid <= (wr_ptr_nx != rd_ptr_nx);
            if (push && wr_ptr[AW-1:0] == rd_ptr_nx[AW-1:0]) begin
                oData <= cap_word;
            end else begin
                oData <= mem[rd_ptr_nx[AW-1:0]];
            end
        end
    end

    assign oTdcRst = !iRst && (state == S_ARM);
    assign oArm    = !iRst && (state == S_WAIT);
    assign oBusy   = !iRst && (state != S_IDLE);
    assign oDone   = !iRst && (state == S_DONE);

endmodule

// File: tb/tb_tdc_readout_ctrl.sv
module tb_tdc_readout_ctrl;

    localparam int W     = 24;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [7:0]    shots;
    logic          tdc_rst;
    logic          arm;
    logic          tdc_valid;
    logic [W-1:0]  tdc;
    logic [W-1:0]  data;
    logic          valid;
    logic          ready;
    logic          busy;
    logic          done;
    logic          ovf;
    logic          tmo;

    int            n_cmp = 0;
    int            n_err = 0;
    int            rst_pulses = 0;
    int            done_pulses = 0;
    logic [W-1:0]  exp_q[$];

    tdc_readout_ctrl #(
        .DIG_OUT        (W),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .iClk      (clk),
        .iRst      (rst),
        .iStart    (start),
        .iAbort    (abort),
        .iShots    (shots),
        .oTdcRst   (tdc_rst),
        .oArm      (arm),
        .iTdcValid (tdc_valid),
        .iTdc      (tdc),
        .oData     (data),
        .oValid    (valid),
        .iReady    (ready),
        .oBusy     (busy),
        .oDone     (done),
        .oOverflow (ovf),
        .oTimeout  (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: every accepted word leaves the DUT in push order.
    always @(negedge clk) begin
        if (!rst) begin
            if (tdc_rst) rst_pulses++;
            if (done) done_pulses++;
            if (valid && ready) begin
                check("sb_nonempty", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("data_order", data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] n);
        shots = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_arm();
        for (int n = 0; n < 200 && !arm; n++) tick();
        check("arm_reached", arm, 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && busy; n++) tick();
        check("idle_reached", busy, 0);
    endtask

    // Deliver one conversion in WAIT; returns in the following STORE cycle.
    task automatic convert(input logic [W-1:0] word, input bit keep);
        wait_arm();
        tdc_valid = 1'b1;
        tdc       = word;
        if (keep) exp_q.push_back(word);
        tick();
        tdc_valid = 1'b0;
        tdc       = W'($urandom);
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
        check("drain_empty", exp_q.size(), 0);
        tick();
        tick();
        check("valid_after_drain", valid, 0);
    endtask

    task automatic clear_counts();
        rst_pulses  = 0;
        done_pulses = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] basic_words [3];
        basic_words[0] = 24'h00A123;
        basic_words[1] = 24'h00B456;
        basic_words[2] = 24'h00C789;

        rst = 1'b1; start = 1'b0; abort = 1'b0; shots = '0;
        tdc_valid = 1'b0; tdc = '0; ready = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_tdcrst", tdc_rst, 0);
        check("rst_arm",    arm,     0);
        check("rst_valid",  valid,   0);
        check("rst_data",   data,    0);
        check("rst_busy",   busy,    0);
        check("rst_done",   done,    0);
        check("rst_ovf",    ovf,     0);
        check("rst_tmo",    tmo,     0);
        rst = 1'b0;
        tick();

        // Basic three-shot run with latency check
        ready = 1'b1;
        clear_counts();
        pulse_start(8'd3);
        check("busy_after_start", busy, 1);
        for (int i = 0; i < 3; i++) begin
            convert(basic_words[i], 1'b1);
            check("valid_lat1", valid, 0);
            tick();
            check("valid_lat2", valid, 1);
            check("data_lat2", data, basic_words[i]);
        end
        wait_idle();
        tick();
        check("basic_tdcrst_pulses", rst_pulses, 3);
        check("basic_done_pulses", done_pulses, 1);
        check("basic_sb_empty", exp_q.size(), 0);

        // Conversion pulse outside WAIT is ignored
        tdc_valid = 1'b1; tdc = 24'h0BAD00;
        tick();
        tdc_valid = 1'b0;
        tick();
        tick();
        check("idle_valid_ignored", valid, 0);
        check("idle_stays_idle", busy, 0);

        // Overflow: ten conversions into an eight-deep buffer, consumer stalled
        ready = 1'b0;
        clear_counts();
        pulse_start(8'd10);
        for (int i = 0; i < 10; i++) convert(24'h100000 + W'(i), i < DEPTH);
        wait_idle();
        tick();
        check("ovf_set", ovf, 1);
        check("ovf_done_pulses", done_pulses, 1);
        check("ovf_head_valid", valid, 1);
        check("ovf_head_data", data, 24'h100000);
        drain();

        // Full FIFO: push and pop in the same STORE cycle are both taken
        ready = 1'b0;
        clear_counts();
        pulse_start(8'd9);
        check("ovf_cleared_by_start", ovf, 0);
        for (int i = 0; i < DEPTH; i++) convert(24'h200000 + W'(i), 1'b1);
        convert(24'h2000FF, 1'b1);
        ready = 1'b1;
        wait_idle();
        check("simul_no_ovf", ovf, 0);
        check("simul_done_pulses", done_pulses, 1);
        drain();

        // iStart with iAbort in IDLE: no run
        clear_counts();
        shots = 8'd2; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        tick();
        tick();
        check("start_abort_busy2", busy, 0);
        check("start_abort_no_tdcrst", rst_pulses, 0);

        // Continuous run aborted in WAIT; buffered words survive
        ready = 1'b0;
        clear_counts();
        pulse_start(8'd0);
        convert(24'h300001, 1'b1);
        convert(24'h300002, 1'b1);
        wait_arm();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_arm_low", arm, 0);
        for (int i = 0; i < 5; i++) tick();
        check("abort_no_done", done_pulses, 0);
        check("abort_tdcrst_pulses", rst_pulses, 3);
        check("abort_words_kept", valid, 1);
        check("abort_head", data, 24'h300001);
        drain();

        // WAIT timeout (16 cycles) then a late conversion
        ready = 1'b1;
        clear_counts();
        pulse_start(8'd1);
        wait_arm();
        for (int i = 0; i < 16; i++) tick();
`ifdef TDC_READOUT_TIMEOUT_EN
        check("tmo_set", tmo, 1);
        check("tmo_rearm", tdc_rst, 1);
`else
        check("tmo_absent", tmo, 0);
        check("tmo_still_wait", arm, 1);
`endif
        convert(24'h000001, 1'b1);
        wait_idle();
        tick();
`ifdef TDC_READOUT_TIMEOUT_EN
        check("tmo_tdcrst_pulses", rst_pulses, 2);
        check("tmo_sticky", tmo, 1);
`else
        check("tmo_tdcrst_pulses", rst_pulses, 1);
`endif
        check("tmo_done_pulses", done_pulses, 1);
        check("tmo_sb_empty", exp_q.size(), 0);

        // Conversion in the expiry cycle wins over the timeout
        clear_counts();
        pulse_start(8'd1);
        check("tmo_cleared_by_start", tmo, 0);
        wait_arm();
        for (int i = 0; i < 15; i++) tick();
        convert(24'h0000E5, 1'b1);
        wait_idle();
        tick();
        check("expiry_tdcrst_pulses", rst_pulses, 1);
        check("expiry_no_tmo", tmo, 0);
        check("expiry_done_pulses", done_pulses, 1);

        // Reset during STORE with three words buffered
        ready = 1'b0;
        clear_counts();
        pulse_start(8'd5);
        for (int i = 0; i < 3; i++) convert(24'h400000 + W'(i), 1'b1);
        convert(24'h4000FF, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("midrst_tdcrst", tdc_rst, 0);
        check("midrst_arm",    arm,     0);
        check("midrst_valid",  valid,   0);
        check("midrst_data",   data,    0);
        check("midrst_busy",   busy,    0);
        check("midrst_done",   done,    0);
        check("midrst_ovf",    ovf,     0);
        check("midrst_tmo",    tmo,     0);
        rst = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_empty", valid, 0);
        check("post_rst_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdc_readout_ctrl.md
TDC_READOUT_CTRL -- requirements
Module: tdc_readout_ctrl

Interface
REQ-001 Parameters, one per line:
- DIG_OUT, 24, width of a TDC result word.
- FIFO_DEPTH, 8, result buffer depth; power of 2, at least 2.
- TIMEOUT_CYCLES, 1023, WAIT-state cycle limit; minimum 1.
REQ-002 iClk  in  1  single clock; all logic on its rising edge.
REQ-003 iRst  in  1  reset; synchronous and active-high.
REQ-004 iStart  in  1  one-cycle request to begin a run.
REQ-005 iAbort  in  1  one-cycle request to end a run immediately.
REQ-006 iShots  in  8  shots per run, sampled on accepted iStart; 0 means continuous.
REQ-007 oTdcRst  out  1  one-cycle reset to the TDC datapath before each shot.
REQ-008 oArm  out  1  high while the controller waits for a conversion.
REQ-009 iTdcValid  in  1  one-cycle pulse: conversion finished.
REQ-010 iTdc  in  DIG_OUT  result word; valid only with iTdcValid.
REQ-011 oData  out  DIG_OUT  FIFO head word.
REQ-012 oValid  out  1  oData is valid.
REQ-013 iReady  in  1  consumer accepts oData.
REQ-014 oBusy  out  1  a run is in progress, i.e. the state is not IDLE.
REQ-015 oDone  out  1  one-cycle pulse at normal run completion.
REQ-016 oOverflow  out  1  sticky: a result was dropped because the FIFO was full.
REQ-017 oTimeout  out  1  sticky: a WAIT state timed out.

Function
REQ-018 The state machine SHALL have the states IDLE, ARM, WAIT, STORE and DONE, with transitions as follows:
- IDLE to ARM on iStart.
- ARM to WAIT after one cycle, with oTdcRst=1 during ARM.
- WAIT to STORE on iTdcValid, with oArm=1 throughout WAIT.
- STORE to ARM if shots remain or the run is continuous; otherwise STORE to DONE.
- DONE to IDLE after one cycle, with oDone=1 during DONE.
REQ-019 The block SHALL capture iTdc on iTdcValid in WAIT and push it to the FIFO during the following STORE cycle.
REQ-020 oValid SHALL rise two cycles after iTdcValid when the FIFO was empty.
REQ-021 The block SHALL ignore iTdcValid outside WAIT.
REQ-022 The remaining-shot counter SHALL load iShots on accepted iStart, decrement once per STORE, and end the run when it reaches 0 after a decrement.
REQ-023 With iShots=0, the run SHALL continue until iAbort.
REQ-024 The block SHALL ignore iStart while oBusy=1.
REQ-025 iAbort in any non-IDLE state SHALL force IDLE on the next cycle with no oDone pulse and no push, and SHALL leave FIFO contents intact.
REQ-026 If iStart and iAbort are both high in IDLE, abort SHALL win and no run starts.
REQ-027 The FIFO SHALL be first-word-fall-through: oData and oValid are registered, and oData holds stable while oValid=1 and iReady=0.
REQ-028 A pop SHALL occur when oValid=1 and iReady=1.
REQ-029 Full and empty detection SHALL use log2(FIFO_DEPTH)+1-bit pointers, with wrap-around through the extra MSB.
REQ-030 A push to a full FIFO with no pop in the same cycle SHALL drop the word, set oOverflow, and still count the shot.
REQ-031 A push and a pop in the same cycle on a full FIFO SHALL both be accepted, leaving the occupancy unchanged.
REQ-032 A push and a pop in the same cycle on an empty FIFO SHALL NOT bypass: the word appears on oData on the next cycle.
REQ-033 oOverflow and oTimeout SHALL clear only on iRst or on an accepted iStart.

Reset
REQ-034 While iRst=1, the block SHALL enter IDLE and empty the FIFO.
REQ-035 While iRst=1, the outputs SHALL be oTdcRst=0, oArm=0, oValid=0, oData=0, oBusy=0, oDone=0, oOverflow=0 and oTimeout=0.
REQ-036 While iRst=1, the shot and timeout counters SHALL be 0.
REQ-037 iRst mid-run SHALL discard any captured word and any buffered words, and SHALL have priority over all other inputs.

Configuration
REQ-038 The macro TDC_READOUT_TIMEOUT_EN SHALL compile the WAIT timeout in or out.
REQ-039 With TDC_READOUT_TIMEOUT_EN defined:
- A counter clears on entry to WAIT.
- After TIMEOUT_CYCLES cycles in WAIT with no iTdcValid, the block sets oTimeout and returns to ARM.
- No push occurs and no shot is counted.
- If iTdcValid arrives in the expiry cycle, it wins and the block goes to STORE.
REQ-040 Without TDC_READOUT_TIMEOUT_EN, the timeout counter and its logic SHALL be absent, WAIT SHALL last indefinitely, and oTimeout SHALL be tied to 0.

Verification
REQ-041 The bench SHALL cover a basic run: iShots=3, iStart, then iTdcValid with iTdc=0x00A123, 0x00B456 and 0x00C789 during WAIT, with iReady=1 → exactly 3 oTdcRst pulses, the words output in order, and one oDone; oValid rises 2 cycles after each iTdcValid.
REQ-042 The bench SHALL cover overflow: iShots=10, iReady=0, 10 conversions → the first 8 words are held, oOverflow=1, and oDone pulses; releasing iReady then yields exactly 8 words in order.
REQ-043 The bench SHALL cover abort in WAIT: iShots=0, 2 conversions, then iAbort during WAIT → IDLE next cycle, oDone never pulses, and the 2 words remain readable.
REQ-044 The bench SHALL cover timeout with TDC_READOUT_TIMEOUT_EN and TIMEOUT_CYCLES=16: iShots=1 and no iTdcValid for 16 WAIT cycles → oTimeout=1 and a second oTdcRst pulse; a following iTdcValid with 0x000001 → one word and oDone.
REQ-045 The bench SHALL cover simultaneous events: a full FIFO with a STORE push and a pop in the same cycle → both accepted and oOverflow stays 0; iStart together with iAbort in IDLE → oBusy stays 0.
REQ-046 The bench SHALL cover reset mid-run: iRst asserted during STORE with 3 words buffered → on the next cycle all outputs are at reset values and oValid=0.
